// File: rtl/stack_ctrl_pkg.sv
// stack_ctrl_pkg: shared widths, depth and FSM encodings for the stack controller.
package stack_ctrl_pkg;
    localparam int DATA_WIDTH = 12;
    localparam int ADDR_WIDTH = 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
    typedef enum logic {
        STATE_IDLE,
        STATE_SETTLE
    } state_e;
endpackage

// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if: command side and memory side of the stack controller.
interface stack_ctrl_if;
    import stack_ctrl_pkg::*;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  clear_err;
    logic                  cmd_ready;
    logic [DATA_WIDTH-1:0] pop_data;
    logic                  pop_valid;
    logic [DATA_WIDTH-1:0] top_data;
    logic                  top_valid;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic                  underflow;
    logic                  cmd_err;
    logic [DATA_WIDTH-1:0] mem_in_data;
    logic [ADDR_WIDTH-1:0] mem_in_address;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_out_address;
    logic [DATA_WIDTH-1:0] mem_out_data;
    modport slave (
        input  push, pop, push_data, clear_err, mem_out_data,
        output cmd_ready, pop_data, pop_valid, top_data, top_valid, count, full, empty,
               overflow, underflow, cmd_err, mem_in_data, mem_in_address, mem_we, mem_out_address
    );
    modport master (
        output push, pop, push_data, clear_err, mem_out_data,
        input  cmd_ready, pop_data, pop_valid, top_data, top_valid, count, full, empty,
               overflow, underflow, cmd_err, mem_in_data, mem_in_address, mem_we, mem_out_address
    );
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: push/pop sequencer owning the stack pointer; read address moves one edge after any write.
module stack_ctrl
    import stack_ctrl_pkg::*;
(
    input logic        clock,
    input logic        reset_n,
    stack_ctrl_if.slave bus
);
    state_e                state_q;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [DATA_WIDTH-1:0] pop_data_q;
    logic                  pop_valid_q, ovf_q, udf_q, err_q;
    logic                  idle, full, empty, both, do_push, do_pop, ovf_set, udf_set;
    always_comb begin
        idle    = state_q == STATE_IDLE;
        full    = count_q == FULL_COUNT;
        empty   = count_q == '0;
        both    = idle && bus.push && bus.pop;
        do_push = idle && bus.push && !bus.pop && !full;
        do_pop  = idle && bus.pop && !bus.push && !empty;
        ovf_set = idle && bus.push && !bus.pop && full;
        udf_set = idle && bus.pop && !bus.push && empty;
        count_d = do_push ? count_q + 1'b1 : do_pop ? count_q - 1'b1 : count_q;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= STATE_IDLE;
            count_q     <= '0;
            rd_addr_q   <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= (do_push || do_pop) ? STATE_SETTLE : STATE_IDLE;
            count_q     <= count_d;
            pop_valid_q <= do_pop;
            if (do_pop) pop_data_q <= bus.mem_out_data;
            // count_q already holds the post-access value while settling
            if (state_q == STATE_SETTLE)
                rd_addr_q <= empty ? '0 : ADDR_WIDTH'(count_q - 1'b1);
            ovf_q <= (ovf_q && !bus.clear_err) || ovf_set;
            udf_q <= (udf_q && !bus.clear_err) || udf_set;
            err_q <= (err_q && !bus.clear_err) || both;
        end
    end
    assign bus.cmd_ready       = idle;
    assign bus.pop_data        = pop_data_q;
    assign bus.pop_valid       = pop_valid_q;
    assign bus.top_data        = bus.mem_out_data;
    assign bus.top_valid       = idle && !empty;
    assign bus.count           = count_q;
    assign bus.full            = full;
    assign bus.empty           = empty;
    assign bus.overflow        = ovf_q;
    assign bus.underflow       = udf_q;
    assign bus.cmd_err         = err_q;
    assign bus.mem_we          = do_push;
    assign bus.mem_in_address  = do_push ? count_q[ADDR_WIDTH-1:0] : '0;
    assign bus.mem_in_data     = do_push ? bus.push_data : '0;
    assign bus.mem_out_address = rd_addr_q;
endmodule
